// File: rtl/strip_scan_sequencer_if.sv
// strip_scan_sequencer_if: control, configuration, pulser/mux and result
// signals of the strip scan sequencer. The master is the register/control
// side. The slave is the sequencer.
interface strip_scan_sequencer_if #(
  parameter int NSTRIPS  = 16,
  parameter int SETTLE_W = 8
);
  logic                start;
  logic                abort;
  logic [3:0]          first_strip;
  logic [3:0]          last_strip;
  logic [15:0]         num_pulses;
  logic [SETTLE_W-1:0] settle_cycles;
  logic [3:0]          window_cycles;
  logic [31:0]         halfstrips;
  logic [31:0]         halfstrips_expect;
  logic                pulser_ready;
  logic [NSTRIPS-1:0]  mux_sel;
  logic                fire_pulse;
  logic                busy;
  logic                done;
  logic [3:0]          cur_strip;
  logic [15:0]         err_cnt;
  logic [NSTRIPS-1:0]  fail_map;
  logic                timeout;

  modport master (
    output start, abort, first_strip, last_strip, num_pulses, settle_cycles,
           window_cycles, halfstrips, halfstrips_expect, pulser_ready,
    input  mux_sel, fire_pulse, busy, done, cur_strip, err_cnt, fail_map, timeout
  );

  modport slave (
    input  start, abort, first_strip, last_strip, num_pulses, settle_cycles,
           window_cycles, halfstrips, halfstrips_expect, pulser_ready,
    output mux_sel, fire_pulse, busy, done, cur_strip, err_cnt, fail_map, timeout
  );
endinterface

// File: rtl/strip_scan_sequencer.sv
// strip_scan_sequencer: pulse-injection scan over a strip range. For each
// strip, the sequencer selects the strip on the mux and waits for the mux to
// settle. It then fires the programmed number of pulses and ORs the
// half-strip hits over a readout window after each pulse. Each window result
// is compared with the expected pattern.
// Optional build macro: STRIP_SCAN_TIMEOUT_EN adds a pulser_ready watchdog.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | waiting for start; mux deselected
// S_SETTLE | strip selected, settle down-counter running
// S_FIRE   | waiting for pulser_ready, then fires one pulse
// S_WINDOW | OR-accumulating half-strip hits for window_cycles+1 cycles
// S_CHECK  | compares accumulated hits, advances the pulse counter
// S_NEXT   | ends the scan after the last strip, or steps to the next strip
module strip_scan_sequencer #(
  parameter int NSTRIPS  = 16,
  parameter int SETTLE_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  strip_scan_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_FIRE, S_WINDOW, S_CHECK, S_NEXT
  } state_t;

  state_t              state;
  logic [3:0]          last_cfg;
  logic [3:0]          window_cfg;
  logic [15:0]         pulses_cfg;
  logic [SETTLE_W-1:0] settle_cfg;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [3:0]          win_cnt;
  logic [15:0]         pulse_cnt;
  logic [31:0]         hit_acc;
  logic                done_pend;
`ifdef STRIP_SCAN_TIMEOUT_EN
  logic [11:0]         wd_cnt;
`endif

  function automatic logic [NSTRIPS-1:0] strip_onehot(input logic [3:0] idx);
    return {{(NSTRIPS-1){1'b0}}, 1'b1} << idx;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Scan FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      last_cfg      <= '0;
      window_cfg    <= '0;
      pulses_cfg    <= '0;
      settle_cfg    <= '0;
      settle_cnt    <= '0;
      win_cnt       <= '0;
      pulse_cnt     <= '0;
      hit_acc       <= '0;
      done_pend     <= 1'b0;
`ifdef STRIP_SCAN_TIMEOUT_EN
      wd_cnt        <= '0;
`endif
      bus.mux_sel    <= '0;
      bus.fire_pulse <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.cur_strip  <= '0;
      bus.err_cnt    <= '0;
      bus.fail_map   <= '0;
      bus.timeout    <= 1'b0;
    end else begin
      bus.fire_pulse <= 1'b0;
      // An empty range reports done two cycles after start, via done_pend.
      bus.done       <= done_pend;
      done_pend      <= 1'b0;
      if (state != S_IDLE && bus.abort) begin
        // On abort the results freeze and no done strobe is produced.
        state       <= S_IDLE;
        bus.busy    <= 1'b0;
        bus.mux_sel <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start && !bus.abort) begin
              last_cfg      <= bus.last_strip;
              window_cfg    <= bus.window_cycles;
              pulses_cfg    <= (bus.num_pulses == 16'd0) ? 16'd1 : bus.num_pulses;
              settle_cfg    <= bus.settle_cycles;
              bus.cur_strip <= bus.first_strip;
              bus.err_cnt   <= '0;
              bus.fail_map  <= '0;
              bus.timeout   <= 1'b0;
              if (bus.first_strip > bus.last_strip) begin
                done_pend <= 1'b1;
              end else begin
                state       <= S_SETTLE;
                bus.busy    <= 1'b1;
                bus.mux_sel <= strip_onehot(bus.first_strip);
                settle_cnt  <= bus.settle_cycles;
                pulse_cnt   <= '0;
              end
            end
          end
          S_SETTLE: begin
            if (settle_cnt == '0) begin
              state <= S_FIRE;
`ifdef STRIP_SCAN_TIMEOUT_EN
              wd_cnt <= 12'hFFF;
`endif
            end else begin
              settle_cnt <= settle_cnt - 1'b1;
            end
          end
          S_FIRE: begin
            if (bus.pulser_ready) begin
              bus.fire_pulse <= 1'b1;
              hit_acc        <= '0;
              win_cnt        <= window_cfg;
              state          <= S_WINDOW;
            end
`ifdef STRIP_SCAN_TIMEOUT_EN
            // On watchdog expiry, the pulse counts as a mismatch and the
            // remaining pulses of this strip are skipped.
            else if (wd_cnt == 12'd0) begin
              bus.timeout                <= 1'b1;
              bus.err_cnt                <= sat_inc(bus.err_cnt);
              bus.fail_map[bus.cur_strip] <= 1'b1;
              state                      <= S_NEXT;
            end else begin
              wd_cnt <= wd_cnt - 1'b1;
            end
`endif
          end
          S_WINDOW: begin
            hit_acc <= hit_acc | bus.halfstrips;
            if (win_cnt == 4'd0) state <= S_CHECK;
            else                 win_cnt <= win_cnt - 1'b1;
          end
          S_CHECK: begin
            if (hit_acc != bus.halfstrips_expect) begin
              bus.err_cnt                <= sat_inc(bus.err_cnt);
              bus.fail_map[bus.cur_strip] <= 1'b1;
            end
            pulse_cnt <= pulse_cnt + 16'd1;
            if (pulse_cnt + 16'd1 < pulses_cfg) begin
              state <= S_FIRE;
`ifdef STRIP_SCAN_TIMEOUT_EN
              wd_cnt <= 12'hFFF;
`endif
            end else begin
              state <= S_NEXT;
            end
          end
          S_NEXT: begin
            if (bus.cur_strip == last_cfg || bus.cur_strip == 4'hF) begin
              state       <= S_IDLE;
              bus.busy    <= 1'b0;
              bus.mux_sel <= '0;
              bus.done    <= 1'b1;
            end else begin
              bus.cur_strip <= bus.cur_strip + 4'd1;
              bus.mux_sel   <= strip_onehot(bus.cur_strip + 4'd1);
              settle_cnt    <= settle_cfg;
              pulse_cnt     <= '0;
              state         <= S_SETTLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_strip_scan_sequencer.sv
// tb_strip_scan_sequencer: directed scans with hand-computed expectations.
module tb_strip_scan_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] hs_val = '0;
  logic        blank3 = 1'b0;

  int          fires, dones, cyc, first_gap, b2b, last_fire;
  logic        prev_fire;
  logic [15:0] mux_q[$];
  logic        busy1;
  logic [15:0] mux1;

  strip_scan_sequencer_if #(.NSTRIPS(16), .SETTLE_W(8)) bus ();

  strip_scan_sequencer #(.NSTRIPS(16), .SETTLE_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Strip 3 can be blanked to model a dead channel.
  assign bus.halfstrips = (blank3 && bus.mux_sel == 16'h0008) ? 32'h0 : hs_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic configure(input logic [3:0] f, input logic [3:0] l,
                           input logic [15:0] np, input logic [7:0] st,
                           input logic [3:0] w);
    bus.first_strip   = f;
    bus.last_strip    = l;
    bus.num_pulses    = np;
    bus.settle_cycles = st;
    bus.window_cycles = w;
  endtask

  task automatic inspect(input int c);
    if (bus.fire_pulse) begin
      fires++;
      if (prev_fire) b2b++;
      if (fires == 2) first_gap = c - last_fire;
      last_fire = c;
    end
    prev_fire = bus.fire_pulse;
    if (bus.mux_sel != 16'h0 && (mux_q.size() == 0 || mux_q[$] != bus.mux_sel))
      mux_q.push_back(bus.mux_sel);
    if (bus.done) dones++;
  endtask

  task automatic pulse_start();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  task automatic run_scan(input int budget, input int tail);
    bit seen = 0;
    fires = 0; dones = 0; cyc = 0; first_gap = 0; b2b = 0;
    last_fire = -100; prev_fire = 1'b0; mux_q.delete();
    pulse_start();
    busy1 = bus.busy;
    mux1  = bus.mux_sel;
    for (int c = 1; c <= budget; c++) begin
      inspect(c);
      if (bus.done) begin
        seen = 1;
        cyc  = c;
        break;
      end
      @(negedge clk);
    end
    chk("done_seen", 32'(seen), 32'd1);
    for (int t = 0; t < tail; t++) begin
      @(negedge clk);
      inspect(cyc + t + 1);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.halfstrips_expect = 32'h0000_0F00;
    bus.pulser_ready = 1'b1;
    configure(4'd0, 4'd0, 16'd1, 8'd0, 4'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mux", 32'(bus.mux_sel), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_err", 32'(bus.err_cnt), 32'h0);
    chk("rst_fail", 32'(bus.fail_map), 32'h0);
    chk("rst_misc", {bus.fire_pulse, bus.done, bus.timeout, bus.cur_strip}, 32'h0);

    // Clean scan of strips 2..4: 3 pulses/strip, 6 cycles per pulse.
    hs_val = 32'h0000_0F00;
    configure(4'd2, 4'd4, 16'd3, 8'd5, 4'd3);
    run_scan(2000, 5);
    chk("t1_busy1", 32'(busy1), 32'd1);
    chk("t1_mux1", 32'(mux1), 32'h4);
    chk("t1_fires", fires, 9);
    chk("t1_gap", first_gap, 6);
    chk("t1_b2b", b2b, 0);
    chk("t1_muxn", mux_q.size(), 3);
    if (mux_q.size() == 3) begin
      chk("t1_mux_a", 32'(mux_q[0]), 32'h4);
      chk("t1_mux_b", 32'(mux_q[1]), 32'h8);
      chk("t1_mux_c", 32'(mux_q[2]), 32'h10);
    end
    chk("t1_err", 32'(bus.err_cnt), 32'h0);
    chk("t1_fail", 32'(bus.fail_map), 32'h0);
    chk("t1_dones", dones, 1);
    chk("t1_idle", {bus.busy, bus.mux_sel}, 32'h0);

    // Strip 3 is blank, so all three of its pulses mismatch.
    blank3 = 1'b1;
    run_scan(2000, 5);
    blank3 = 1'b0;
    chk("t2_fires", fires, 9);
    chk("t2_err", 32'(bus.err_cnt), 32'd3);
    chk("t2_fail", 32'(bus.fail_map), 32'h8);
    chk("t2_cur", 32'(bus.cur_strip), 32'd4);
    chk("t2_dones", dones, 1);

    // Empty range: done two cycles after start, nothing fires.
    configure(4'd5, 4'd3, 16'd3, 8'd5, 4'd3);
    run_scan(10, 3);
    chk("t3_cyc", cyc, 2);
    chk("t3_busy1", 32'(busy1), 32'd0);
    chk("t3_fires", fires, 0);
    chk("t3_muxn", mux_q.size(), 0);
    chk("t3_dones", dones, 1);
    chk("t3_err_clr", 32'(bus.err_cnt), 32'h0);

    // A num_pulses value of 0 behaves as 1.
    configure(4'd1, 4'd1, 16'd0, 8'd2, 4'd1);
    run_scan(200, 3);
    chk("t4_fires", fires, 1);
    chk("t4_dones", dones, 1);

    // Abort in the window of the second pulse. Pulse 1 has already failed.
    hs_val = 32'h0;
    configure(4'd2, 4'd4, 16'd3, 8'd5, 4'd3);
    fires = 0; dones = 0; prev_fire = 1'b0; last_fire = -100; b2b = 0;
    pulse_start();
    for (int c = 1; c <= 500 && fires < 2; c++) begin
      inspect(c);
      if (fires < 2) @(negedge clk);
    end
    chk("t5_reach", fires, 2);
    bus.abort = 1'b1;
    @(negedge clk) bus.abort = 1'b0;
    chk("t5_busy", 32'(bus.busy), 32'd0);
    chk("t5_mux", 32'(bus.mux_sel), 32'h0);
    chk("t5_err", 32'(bus.err_cnt), 32'd1);
    fires = 0; dones = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      inspect(c);
    end
    chk("t5_nodone", dones, 0);
    chk("t5_nofire", fires, 0);
    chk("t5_err_hold", 32'(bus.err_cnt), 32'd1);
    chk("t5_fail_hold", 32'(bus.fail_map), 32'h4);

    // When idle, start together with abort does nothing.
    @(negedge clk) begin bus.start = 1'b1; bus.abort = 1'b1; end
    @(negedge clk) begin bus.start = 1'b0; bus.abort = 1'b0; end
    chk("t5_sa_busy", {bus.busy, bus.mux_sel}, 32'h0);

    // Pulser never becomes ready on strip 7.
    hs_val = 32'h0000_0F00;
    bus.pulser_ready = 1'b0;
    configure(4'd7, 4'd7, 16'd1, 8'd0, 4'd0);
`ifdef STRIP_SCAN_TIMEOUT_EN
    run_scan(6000, 3);
    chk("t6_timeout", 32'(bus.timeout), 32'd1);
    chk("t6_err", 32'(bus.err_cnt), 32'd1);
    chk("t6_fail", 32'(bus.fail_map), 32'h80);
    chk("t6_dones", dones, 1);
    chk("t6_late", 32'(cyc > 4095), 32'd1);
    chk("t6_fires", fires, 0);
`else
    fires = 0; dones = 0; prev_fire = 1'b0;
    pulse_start();
    for (int c = 0; c < 5000; c++) begin
      inspect(c);
      @(negedge clk);
    end
    chk("t6_busy", 32'(bus.busy), 32'd1);
    chk("t6_timeout", 32'(bus.timeout), 32'd0);
    chk("t6_fires", fires, 0);
    chk("t6_mux", 32'(bus.mux_sel), 32'h80);
    bus.abort = 1'b1;
    @(negedge clk) bus.abort = 1'b0;
    chk("t6_abort", 32'(bus.busy), 32'd0);
`endif
    bus.pulser_ready = 1'b1;

    // Reset during SETTLE, then run a normal scan.
    configure(4'd2, 4'd4, 16'd3, 8'd20, 4'd3);
    pulse_start();
    repeat (3) @(negedge clk);
    chk("t7_pre", {bus.busy, bus.cur_strip}, 32'h12);
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    chk("t7_mux", 32'(bus.mux_sel), 32'h0);
    chk("t7_misc", {bus.busy, bus.fire_pulse, bus.done, bus.timeout, bus.cur_strip}, 32'h0);
    chk("t7_res", {bus.err_cnt, bus.fail_map}, 32'h0);
    configure(4'd2, 4'd4, 16'd3, 8'd5, 4'd3);
    run_scan(2000, 5);
    chk("t7_fires", fires, 9);
    chk("t7_err", 32'(bus.err_cnt), 32'h0);
    chk("t7_dones", dones, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
